// File: rtl/sopc_system_cpu_oci_trace_capture_if.sv
// Valid/ready read port of the OCI trace capture buffer.
// The master side presents {count, buffer} frames and the slave side consumes them.
interface sopc_system_cpu_oci_trace_capture_if #(
  parameter int WIDTH = 34
);
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/sopc_system_cpu_oci_trace_capture.sv
// Capture buffer for the CPU OCI debug-trace stream: a first-word-fall-through FIFO
// with drop counting and graceful-drain / hard-freeze end-of-test handling.
module sopc_system_cpu_oci_trace_capture #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   dct_buffer,
  input  logic [CNT_W-1:0]    dct_count,
  input  logic                dct_valid,
  input  logic                test_ending,
  input  logic                test_has_ended,
  input  logic                arm,
  sopc_system_cpu_oci_trace_capture_if.master rd,
  output logic [ADDR_W:0]     fill_level,
  output logic [OVF_W-1:0]    overflow_cnt,
  output logic [1:0]          state,
  output logic                done
);

  localparam int FRAME_W = CNT_W + DATA_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;
  logic [FRAME_W-1:0]  mem_q [DEPTH];

  logic rd_valid_w;
  logic pop_w;
  logic wr_w;
  logic accept_w;
  logic drop_w;

  // A full FIFO still takes a frame when the head leaves on the same edge.
  assign rd_valid_w = (fill_q != '0) && (state_q != ST_DONE);
  assign pop_w      = rd_valid_w && rd.rd_ready;
  assign wr_w       = (state_q == ST_CAPTURE) && dct_valid && (dct_count != '0);
  assign accept_w   = wr_w && ((fill_q != DEPTH_L) || pop_w);
  assign drop_w     = wr_w && !accept_w;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;

    if (accept_w) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({accept_w, pop_w})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    if (drop_w && (ovf_q != '1)) begin
      ovf_d = ovf_q + 1'b1;
    end

    case (state_q)
      ST_CAPTURE: begin
        if (test_has_ended) begin
          state_d = ST_DONE;
        end else if (test_ending) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (test_has_ended || (fill_q == '0) ||
            ((fill_q == (ADDR_W + 1)'(1)) && pop_w)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Re-arming starts a fresh capture session with nothing carried over.
        if (arm) begin
          state_d  = ST_CAPTURE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          fill_d   = '0;
          ovf_d    = '0;
        end
      end
      default: begin
        state_d = ST_CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_CAPTURE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_w) begin
      mem_q[wr_ptr_q] <= {dct_count, dct_buffer};
    end
  end

  // Storage is never reset, so the head is masked to zero whenever it is not valid.
  assign rd.rd_valid  = rd_valid_w;
  assign rd.rd_data   = rd_valid_w ? mem_q[rd_ptr_q] : '0;

  assign fill_level   = fill_q;
  assign overflow_cnt = ovf_q;
  assign state        = state_q;
  assign done         = (state_q == ST_DONE);

endmodule
